aes_in_queue: RTL and testbench
===============================

AES_IN_QUEUE -- requirements
Module: aes_in_queue

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent input channels; legal range 1..8.
REQ-002 Parameter DEPTH, default 32: entries per channel; must be a power of 2, 2..256.
REQ-003 Parameter WIDTH, default 131: packet width (128 data + en_de + set_key + valid).
REQ-004 Parameter AFULL_TH, default DEPTH-4: level at or above which afull asserts.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 wr_en  input  NUM_CH  per-channel push strobe.
REQ-008 din  input  NUM_CH*WIDTH  per-channel push data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 flush  input  NUM_CH  per-channel synchronous discard of all stored entries.
REQ-010 full, afull, empty  output  NUM_CH each  per-channel status.
REQ-011 level  output  NUM_CH*($clog2(DEPTH)+1)  per-channel occupancy, 0..DEPTH.
REQ-012 rd_en  input  1  engine pop strobe (driven by load_data & start).
REQ-013 dout  output  WIDTH  head packet of granted channel (show-ahead).
REQ-014 dout_ch  output  max(1,$clog2(NUM_CH))  index of granted channel.
REQ-015 dout_valid  output  1  at least one channel non-empty.
REQ-016 err_ovf, err_udf  output  NUM_CH, 1  sticky error flags (see Configuration).

Function
REQ-017 Each channel SHALL be a circular buffer with read/write pointers wrapping DEPTH-1 -> 0 and a separate count, so full (level==DEPTH) and empty (level==0) are unambiguous.
REQ-018 full, afull (level>=AFULL_TH), empty and level SHALL be combinational from registered count.
REQ-019 Grant SHALL be combinational: first non-empty channel searching upward from rr_ptr with wrap; dout/dout_ch SHALL reflect the granted channel's head with zero latency.
REQ-020 dout SHALL be all-zero and dout_ch 0 when dout_valid=0.
REQ-021 rd_en with dout_valid=1 SHALL pop the granted channel and set rr_ptr to (grant+1) mod NUM_CH on the same edge.
REQ-022 rd_en with dout_valid=0 SHALL change no state except the underflow flag.
REQ-023 Push to a non-full channel SHALL store din and increment level on the edge.
REQ-024 Push to a full channel SHALL be dropped, unless the same channel is popped that cycle, in which case push is accepted and level stays DEPTH.
REQ-025 Simultaneous push and pop on a non-full, non-empty channel SHALL leave level unchanged; on an empty channel the pushed packet is not visible until the next cycle (no fall-through).
REQ-026 flush[i] SHALL zero channel i pointers and count on the edge, overriding push and pop to channel i that cycle; a pop granted to a flushed channel is discarded and rr_ptr still advances.
REQ-027 Packet order within a channel SHALL be strictly FIFO; no channel SHALL wait more than NUM_CH-1 pops while non-empty.

Reset
REQ-028 rstn low SHALL immediately clear all pointers, counts, rr_ptr and error flags: empty all 1, full/afull 0, level 0, dout_valid 0, dout 0, dout_ch 0.
REQ-029 Storage arrays SHALL NOT be reset; reset mid-transfer discards all in-flight packets, and the first push after deassertion is the first packet out.

Configuration
REQ-030 Macro AES_INQ_ERR_EN defined: err_ovf[i] sets on a dropped push to channel i, err_udf sets on rd_en with dout_valid=0; flags clear only on reset or flush of that channel (err_udf only on reset).
REQ-031 AES_INQ_ERR_EN undefined: err_ovf and err_udf ports remain, tied to 0, with no flag registers.

Verification
REQ-032 Reset, push 3 packets to ch0 (data 0x..01/02/03) -> level[0]=3, dout=0x..01, dout_ch=0 one cycle after last push; three rd_en pops return 01,02,03 then dout_valid=0.
REQ-033 ch0 and ch1 each hold 4 packets, rd_en held high 8 cycles -> dout_ch sequence 0,1,0,1,0,1,0,1, per-channel order preserved.
REQ-034 Fill ch1 to 32 -> full[1]=1, afull[1] from level 28; 33rd push alone dropped, err_ovf[1]=1 (macro on) or 0 (macro off); push+pop on ch1 same cycle -> level stays 32, new packet appears last.
REQ-035 rd_en on all-empty queue -> no state change, err_udf=1 with AES_INQ_ERR_EN, 0 without.
REQ-036 ch0 holds 5, assert flush[0] with simultaneous push to ch0 -> level[0]=0, empty[0]=1 next cycle, pushed packet discarded, err_ovf[0] cleared.
REQ-037 Assert rstn low mid-stream with 10 packets queued -> all outputs at reset values while low; after release first push is first popped.

Source files
------------

// File: rtl/aes_in_queue.sv
// aes_in_queue: per-channel circular input FIFOs with a round-robin, show-ahead read port.
// Sticky overflow/underflow flags are built only when AES_INQ_ERR_EN is defined.
module aes_in_queue #(
  parameter int NUM_CH   = 2,
  parameter int DEPTH    = 32,
  parameter int WIDTH    = 131,
  parameter int AFULL_TH = DEPTH - 4
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [NUM_CH-1:0]                    wr_en,
  input  logic [NUM_CH*WIDTH-1:0]              din,
  input  logic [NUM_CH-1:0]                    flush,
  output logic [NUM_CH-1:0]                    full,
  output logic [NUM_CH-1:0]                    afull,
  output logic [NUM_CH-1:0]                    empty,
  output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]  level,
  input  logic                                 rd_en,
  output logic [WIDTH-1:0]                     dout,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] dout_ch,
  output logic                                 dout_valid,
  output logic [NUM_CH-1:0]                    err_ovf,
  output logic                                 err_udf
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [WIDTH-1:0] mem_q [NUM_CH][DEPTH];
  logic [PW-1:0]    wr_ptr_q [NUM_CH];
  logic [PW-1:0]    wr_ptr_d [NUM_CH];
  logic [PW-1:0]    rd_ptr_q [NUM_CH];
  logic [PW-1:0]    rd_ptr_d [NUM_CH];
  logic [LW-1:0]    count_q  [NUM_CH];
  logic [LW-1:0]    count_d  [NUM_CH];
  logic [CW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    grant;
  logic             any_ne;
  logic             pop_any;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;

  always_comb begin
    full  = '0;
    afull = '0;
    empty = '0;
    level = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      empty[i]           = (count_q[i] == LW'(0));
      full[i]            = (count_q[i] == LW'(DEPTH));
      afull[i]           = (count_q[i] >= LW'(AFULL_TH));
      level[i*LW +: LW]  = count_q[i];
    end
  end

  // First non-empty channel at or above rr_ptr, wrapping past the top.
  always_comb begin
    grant  = '0;
    any_ne = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!any_ne && !empty[idx]) begin
        any_ne = 1'b1;
        grant  = CW'(idx);
      end
    end
  end

  assign pop_any    = rd_en & any_ne;
  assign dout_valid = any_ne;

  always_comb begin
    dout    = '0;
    dout_ch = '0;
    if (any_ne) begin
      dout    = mem_q[grant][rd_ptr_q[grant]];
      dout_ch = grant;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (pop_any) rr_ptr_d = (grant == CW'(NUM_CH - 1)) ? '0 : grant + CW'(1);
  end

  // A full channel still accepts a push when it is popped on the same edge.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      pop[i]      = pop_any && (grant == CW'(i));
      push[i]     = wr_en[i] && (!full[i] || pop[i]);
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      count_d[i]  = count_q[i];
      if (flush[i]) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
        count_d[i]  = '0;
      end else begin
        if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
        if (pop[i])  rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
        if (push[i] && !pop[i])      count_d[i] = count_q[i] + LW'(1);
        else if (pop[i] && !push[i]) count_d[i] = count_q[i] - LW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
    end
  end

  // Storage is deliberately not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i] && !flush[i]) mem_q[i][wr_ptr_q[i]] <= din[i*WIDTH +: WIDTH];
    end
  end

`ifdef AES_INQ_ERR_EN
  logic [NUM_CH-1:0] err_ovf_q, err_ovf_d;
  logic              err_udf_q, err_udf_d;

  always_comb begin
    err_ovf_d = err_ovf_q;
    for (int i = 0; i < NUM_CH; i++) begin
      err_ovf_d[i] = flush[i] ? 1'b0 : (err_ovf_q[i] | (wr_en[i] & ~push[i]));
    end
    err_udf_d = err_udf_q | (rd_en & ~any_ne);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_ovf_q <= '0;
      err_udf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;
`else
  assign err_ovf = '0;
  assign err_udf = 1'b0;
`endif

endmodule

// File: tb/tb_aes_in_queue.sv
// Self-checking bench for aes_in_queue: vector table for the basic push/pop path,
// per-channel scoreboard queues with a round-robin reference for the corner cases.
module tb_aes_in_queue;

  localparam int NCH = 2;
  localparam int D   = 32;
  localparam int W   = 131;
  localparam int LW  = 6;
`ifdef AES_INQ_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstn;
  logic [NCH-1:0]    wr_en;
  logic [NCH*W-1:0]  din;
  logic [NCH-1:0]    flush;
  logic [NCH-1:0]    full, afull, empty;
  logic [NCH*LW-1:0] level;
  logic              rd_en;
  logic [W-1:0]      dout;
  logic [0:0]        dout_ch;
  logic              dout_valid;
  logic [NCH-1:0]    err_ovf;
  logic              err_udf;

  aes_in_queue #(.NUM_CH(NCH), .DEPTH(D), .WIDTH(W), .AFULL_TH(D-4)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .din(din), .flush(flush),
    .full(full), .afull(afull), .empty(empty), .level(level),
    .rd_en(rd_en), .dout(dout), .dout_ch(dout_ch), .dout_valid(dout_valid),
    .err_ovf(err_ovf), .err_udf(err_udf)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [W-1:0] mq [NCH][$];
  int           m_rr;

  typedef struct {
    logic [1:0] wr;
    logic [7:0] d;
    logic       rd;
    int         lvl0;
    logic       vld;
    logic [7:0] dbyte;
  } vec_t;
  vec_t vt [6];

  function automatic logic [W-1:0] mk(input int ch, input int n);
    logic [W-1:0] p;
    p = '0;
    p[7:0]     = 8'(n);
    p[15:8]    = 8'(ch);
    p[W-1:128] = 3'b101;
    return p;
  endfunction

  function automatic int mgrant();
    for (int k = 0; k < NCH; k++) begin
      int idx;
      idx = (m_rr + k) % NCH;
      if (mq[idx].size() != 0) return idx;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn  = 1'b0;
    wr_en = '0;
    din   = '0;
    flush = '0;
    rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int c = 0; c < NCH; c++) mq[c].delete();
    m_rr = 0;
  endtask

  task automatic push(input int ch, input logic [W-1:0] p);
    wr_en = '0;
    wr_en[ch] = 1'b1;
    din[ch*W +: W] = p;
    if (mq[ch].size() < D) mq[ch].push_back(p);
    tick();
    wr_en = '0;
  endtask

  // Checks the show-ahead head against the scoreboard, then pops for one edge.
  task automatic pop(input bit hold);
    int g;
    g = mgrant();
    chk("pop_valid", W'(dout_valid), W'(g >= 0));
    if (g >= 0) begin
      chk("pop_ch", W'(dout_ch), W'(g));
      chk("pop_data", dout, mq[g][0]);
    end
    rd_en = 1'b1;
    tick();
    if (!hold) rd_en = 1'b0;
    if (g >= 0) begin
      void'(mq[g].pop_front());
      m_rr = (g + 1) % NCH;
    end
  endtask

  initial begin
    vt[0] = '{2'b01, 8'd1, 1'b0, 1, 1'b1, 8'd1};
    vt[1] = '{2'b01, 8'd2, 1'b0, 2, 1'b1, 8'd1};
    vt[2] = '{2'b01, 8'd3, 1'b0, 3, 1'b1, 8'd1};
    vt[3] = '{2'b00, 8'd0, 1'b1, 2, 1'b1, 8'd2};
    vt[4] = '{2'b00, 8'd0, 1'b1, 1, 1'b1, 8'd3};
    vt[5] = '{2'b00, 8'd0, 1'b1, 0, 1'b0, 8'd0};

    do_reset();
    chk("rst_empty", W'(empty), W'(2'b11));
    chk("rst_full",  W'(full),  W'(0));
    chk("rst_level", W'(level), W'(0));
    chk("rst_valid", W'(dout_valid), W'(0));

    // Three packets into ch0 then three pops.
    for (int i = 0; i < 6; i++) begin
      wr_en = vt[i].wr;
      din   = '0;
      din[0 +: W] = mk(0, int'(vt[i].d));
      rd_en = vt[i].rd;
      tick();
      chk($sformatf("vec%0d_level0", i), W'(level[0 +: LW]), W'(vt[i].lvl0));
      chk($sformatf("vec%0d_valid", i),  W'(dout_valid), W'(vt[i].vld));
      chk($sformatf("vec%0d_ch", i),     W'(dout_ch), W'(0));
      chk($sformatf("vec%0d_dout", i),   dout, vt[i].vld ? mk(0, int'(vt[i].dbyte)) : '0);
    end
    wr_en = '0;
    rd_en = 1'b0;

    // Round-robin between two loaded channels with rd_en held high.
    do_reset();
    for (int n = 0; n < 4; n++) begin
      push(0, mk(0, 16 + n));
      push(1, mk(1, 32 + n));
    end
    for (int n = 0; n < 8; n++) begin
      chk($sformatf("rr_seq%0d", n), W'(dout_ch), W'(n % 2));
      pop(1'b1);
    end
    rd_en = 1'b0;
    chk("rr_drained", W'(dout_valid), W'(0));

    // Fill ch1, drop an overflow push, then push+pop while full.
    do_reset();
    for (int n = 0; n < D; n++) begin
      push(1, mk(1, n));
      chk($sformatf("fill_afull%0d", n), W'(afull[1]), W'((n + 1) >= D - 4));
    end
    chk("fill_full",  W'(full[1]), W'(1));
    chk("fill_level", W'(level[LW +: LW]), W'(D));
    push(1, mk(1, 200));
    chk("ovf_level", W'(level[LW +: LW]), W'(D));
    chk("ovf_flag",  W'(err_ovf[1]), W'(ERR_ON));
    chk("pp_head", dout, mq[1][0]);
    wr_en = 2'b10;
    din[W +: W] = mk(1, 99);
    rd_en = 1'b1;
    tick();
    wr_en = '0;
    rd_en = 1'b0;
    void'(mq[1].pop_front());
    mq[1].push_back(mk(1, 99));
    m_rr = 0;
    chk("pp_level", W'(level[LW +: LW]), W'(D));
    chk("pp_full",  W'(full[1]), W'(1));
    for (int n = 0; n < D; n++) pop(1'b0);
    chk("drain_empty", W'(empty), W'(2'b11));

    // Underflow on an all-empty queue.
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("udf_level", W'(level), W'(0));
    chk("udf_valid", W'(dout_valid), W'(0));
    chk("udf_flag",  W'(err_udf), W'(ERR_ON));

    // Flush with a simultaneous push; overflow flag set beforehand.
    do_reset();
    for (int n = 0; n < D; n++) push(0, mk(0, n));
    push(0, mk(0, 201));
    chk("ovf0_flag", W'(err_ovf[0]), W'(ERR_ON));
    for (int n = 0; n < D - 5; n++) pop(1'b0);
    chk("hold5_level", W'(level[0 +: LW]), W'(5));
    flush = 2'b01;
    wr_en = 2'b01;
    din[0 +: W] = mk(0, 77);
    tick();
    flush = '0;
    wr_en = '0;
    mq[0].delete();
    chk("flush_level", W'(level[0 +: LW]), W'(0));
    chk("flush_empty", W'(empty[0]), W'(1));
    chk("flush_ovf",   W'(err_ovf[0]), W'(0));
    chk("flush_valid", W'(dout_valid), W'(0));
    push(0, mk(0, 5));
    chk("postflush_level", W'(level[0 +: LW]), W'(1));
    pop(1'b0);

    // Asynchronous reset with packets queued.
    for (int n = 0; n < 5; n++) begin
      push(0, mk(0, 60 + n));
      push(1, mk(1, 70 + n));
    end
    #2 rstn = 1'b0;
    #1;
    chk("arst_empty", W'(empty), W'(2'b11));
    chk("arst_level", W'(level), W'(0));
    chk("arst_valid", W'(dout_valid), W'(0));
    chk("arst_dout",  dout, '0);
    chk("arst_ch",    W'(dout_ch), W'(0));
    chk("arst_afull", W'({full, afull}), W'(0));
    tick();
    chk("arst_hold_empty", W'(empty), W'(2'b11));
    chk("arst_hold_udf",   W'(err_udf), W'(0));
    rstn = 1'b1;
    for (int c = 0; c < NCH; c++) mq[c].delete();
    m_rr = 0;
    push(1, mk(1, 42));
    chk("arst_first_ch", W'(dout_ch), W'(1));
    pop(1'b0);
    chk("arst_done", W'(dout_valid), W'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
